mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU datapath's MAR/MDR bus. It samples the datapath's `Read`/`Write` strobes and the MAR address, and applies a configurable number of wait states. It then returns read data on `Mdatain` (the MDR's memory input) with a one-cycle `mem_done` pulse, or commits MDR data to its internal word array. A preload port lets benches and boot logic fill memory before the control sequence runs.

## Interface
- `ADDR_WIDTH`, 9: address bits; depth = 2^ADDR_WIDTH words (512).
- `DATA_WIDTH`, 32: word width.
- `WAIT_STATES`, 1: extra cycles between request capture and access (0..15).
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `address`  in  ADDR_WIDTH  word address, driven from MAR.
- `Read`  in  1  read strobe (level).
- `Write`  in  1  write strobe (level).
- `MDRdata`  in  DATA_WIDTH  write data, driven from MDR.
- `Mdatain`  out  DATA_WIDTH  read data to MDR's memory input; registered, holds its value between reads.
- `mem_done`  out  1  one-cycle completion pulse, for both reads and writes.
- `busy`  out  1  high whenever the responder is not in IDLE.
- `mem_err`  out  1  sticky flag: `Read` and `Write` were both high at capture.
- `load_en`  in  1  preload write enable.
- `load_addr`  in  ADDR_WIDTH  preload address.
- `load_data`  in  DATA_WIDTH  preload data.

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- **IDLE**
  - Exactly one of `Read`/`Write` high at an edge: latch `address`, the op, and (for writes) `MDRdata`. Load the wait counter with WAIT_STATES. Go to WAIT, or directly to ACCESS if WAIT_STATES=0.
  - Both strobes high: set `mem_err`, perform no access, go to HOLD.
- **WAIT**: decrement the counter each edge; go to ACCESS on the edge the counter reaches 0. Strobe changes during WAIT are ignored, because the request is already latched.
- **ACCESS** (exactly one edge)
  - Read: `Mdatain` <= mem[latched addr].
  - Write: mem[latched addr] <= latched data; `Mdatain` is unchanged.
  - `mem_done` <= 1. Go to HOLD.
- **HOLD**
  - `mem_done` <= 0.
  - Return to IDLE on the first edge where both strobes are low.
  - A strobe held high therefore never retriggers an access; a new request needs a deassertion first.
- **Preload**: when `load_en`=1, mem[`load_addr`] <= `load_data` on the edge, in any state.
  - If it collides with an ACCESS write to the same address on the same edge, the preload wins.
  - If it coincides with an ACCESS read of the same address, the read returns the old contents.
- **`mem_err`**: cleared only by `clear`.
- **Reset** (`clear` high, any time, including mid-access): state=IDLE, `Mdatain`=0, `mem_done`=0, `busy`=0, `mem_err`=0, counter=0.
  - A write still in WAIT is aborted and not committed.
  - Memory contents are not cleared.
- **Addresses**: every `address` value is in range; there is no wrap or out-of-range handling.

## Timing
- Request captured at edge k:
  - `mem_done` is high from edge k+WAIT_STATES+1 to edge k+WAIT_STATES+2.
  - Read data is valid on `Mdatain` from edge k+WAIT_STATES+1 and is held after that.
  - Write data is visible to a subsequent read from edge k+WAIT_STATES+1.
- WAIT_STATES=0: `mem_done` is high one cycle after capture.
- Default WAIT_STATES=1: `mem_done` is high two cycles after capture.
- `busy` is registered: high from edge k through the HOLD exit edge.
- Minimum spacing between back-to-back requests:
  - WAIT_STATES+3 edges when the strobe drops during WAIT.
  - A single-cycle `Read` pulse, as issued in a control step, completes without stalling the responder.
- The datapath's control sequence must keep `MDRin` asserted until `mem_done` is seen. The responder does not track `MDRin`.

## Test plan
1. **Preload and read**: preload mem[0x95]=0x0000_1234. After reset, `Read` high for 1 cycle with `address`=0x95. `mem_done` pulses at capture+2 and `Mdatain`=0x0000_1234 at capture+2.
2. **Write then read back**: `Write` with address 0x38, `MDRdata`=0xDEAD_BEEF. Deassert, then `Read` 0x38. `Mdatain`=0xDEAD_BEEF; two `mem_done` pulses total.
3. **Held strobe**: `Read` held high 10 cycles. Exactly one `mem_done` pulse; `busy` stays high until the cycle after `Read` falls.
4. **Both strobes**: `Read`=`Write`=1. `mem_err`=1, no `mem_done` pulse, memory unchanged. `mem_err` stays 1 until `clear`.
5. **Reset during WAIT**: set WAIT_STATES=3, `Write` 0x10 with 0x5555_5555. Assert `clear` during WAIT. All outputs are 0 and a subsequent read of 0x10 returns the preload value, not 0x5555_5555.
6. **Preload/write collision**: preload 0x20=0xAAAA_AAAA on the same edge as an ACCESS write of 0x20=0xBBBB_BBBB. A later read of 0x20 returns 0xAAAA_AAAA.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR bus: latches a Read/Write request, waits
// WAIT_STATES cycles, performs one access and pulses mem_done. Has a preload port.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] MDRdata,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  busy,
    output logic                  mem_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    op_wr_reg;
    logic [DATA_WIDTH-1:0]   mdatain_reg;
    logic                    done_reg;
    logic                    busy_reg;
    logic                    err_reg;
    logic                    capture;
    logic                    err_set;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Read && Write) begin
                    err_set    = 1'b1;
                    state_next = HOLD;
                end else if (Read || Write) begin
                    capture    = 1'b1;
                    cnt_next   = WS_INIT;
                    state_next = (WS_INIT == 4'd0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                // The counter reaches zero on the edge that moves us to ACCESS.
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = ACCESS;
            end
            ACCESS: state_next = HOLD;
            HOLD: begin
                if (!Read && !Write) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= '0;
            data_reg    <= '0;
            op_wr_reg   <= 1'b0;
            mdatain_reg <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_reg == ACCESS);
            if (err_set) err_reg <= 1'b1;
            if (capture) begin
                addr_reg  <= address;
                data_reg  <= MDRdata;
                op_wr_reg <= Write;
            end
            if (state_reg == ACCESS && !op_wr_reg) mdatain_reg <= mem[addr_reg];
        end
    end

    // Preload is written after the access write so it wins on an address collision;
    // the registered read above sees the pre-edge contents.
    always_ff @(posedge clock) begin
        if (state_reg == ACCESS && op_wr_reg) mem[addr_reg] <= data_reg;
        if (load_en) mem[load_addr] <= load_data;
    end

    assign Mdatain  = mdatain_reg;
    assign mem_done = done_reg;
    assign busy     = busy_reg;
    assign mem_err  = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed plan steps plus randomized transactions on a
// WAIT_STATES=1 instance, and reset-during-WAIT on a WAIT_STATES=3 instance.
module tb_mem_responder;
    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int WS_A = 1;
    localparam int WS_B = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          a_clear, a_rd, a_wr, a_load_en;
    logic [AW-1:0] a_addr, a_load_addr;
    logic [DW-1:0] a_mdr, a_load_data, a_mdatain;
    logic          a_done, a_busy, a_err;

    logic          b_clear, b_rd, b_wr, b_load_en;
    logic [AW-1:0] b_addr, b_load_addr;
    logic [DW-1:0] b_mdr, b_load_data, b_mdatain;
    logic          b_done, b_busy, b_err;

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_A)) dut_a (
        .clock(clock), .clear(a_clear), .address(a_addr), .Read(a_rd), .Write(a_wr),
        .MDRdata(a_mdr), .Mdatain(a_mdatain), .mem_done(a_done), .busy(a_busy),
        .mem_err(a_err), .load_en(a_load_en), .load_addr(a_load_addr), .load_data(a_load_data)
    );

    mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_B)) dut_b (
        .clock(clock), .clear(b_clear), .address(b_addr), .Read(b_rd), .Write(b_wr),
        .MDRdata(b_mdr), .Mdatain(b_mdatain), .mem_done(b_done), .busy(b_busy),
        .mem_err(b_err), .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word arrays plus the last value each Mdatain should hold.
    logic [DW-1:0] mem_a [512];
    logic [DW-1:0] mem_b [512];
    logic [DW-1:0] exp_mdat_a = '0;
    logic [DW-1:0] exp_mdat_b = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        a_load_en = 1'b1; a_load_addr = a; a_load_data = d;
        tick();
        a_load_en = 1'b0;
        mem_a[a] = d;
    endtask

    task automatic preload_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        b_load_en = 1'b1; b_load_addr = a; b_load_data = d;
        tick();
        b_load_en = 1'b0;
        mem_b[a] = d;
    endtask

    // One request on dut_a. Strobe is high for `hold` edges starting at the capture
    // edge k; optional preload lands on edge k+pl_edge.
    task automatic req_a(input string tag, input bit is_wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int hold, input bit pl,
                         input int pl_edge, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        int last;
        last = (WS_A + 2 > hold) ? WS_A + 2 : hold;
        a_rd = !is_wr; a_wr = is_wr; a_addr = a; a_mdr = d;
        a_load_en = pl && (pl_edge == 0); a_load_addr = pa; a_load_data = pd;
        @(posedge clock);
        if (a_load_en) mem_a[pa] = pd;
        #1;
        a_load_en = 1'b0;
        chk({tag, ".busy_cap"}, a_busy, 1);
        chk({tag, ".done_cap"}, a_done, 0);
        for (int i = 1; i <= last; i++) begin
            if (i == hold) begin a_rd = 1'b0; a_wr = 1'b0; end
            a_load_en = pl && (pl_edge == i);
            @(posedge clock);
            if (i == WS_A + 1) begin
                if (is_wr) mem_a[a] = d;
                else       exp_mdat_a = mem_a[a];
            end
            if (a_load_en) mem_a[pa] = pd;
            #1;
            a_load_en = 1'b0;
            chk($sformatf("%s.done@%0d", tag, i), a_done, (i == WS_A + 1));
            chk($sformatf("%s.busy@%0d", tag, i), a_busy, (i < last));
            chk($sformatf("%s.mdat@%0d", tag, i), a_mdatain, exp_mdat_a);
        end
    endtask

    task automatic req_b(input string tag, input bit is_wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        b_rd = !is_wr; b_wr = is_wr; b_addr = a; b_mdr = d;
        tick();
        b_rd = 1'b0; b_wr = 1'b0;
        chk({tag, ".busy_cap"}, b_busy, 1);
        for (int i = 1; i <= WS_B + 2; i++) begin
            @(posedge clock);
            if (i == WS_B + 1) begin
                if (is_wr) mem_b[a] = d;
                else       exp_mdat_b = mem_b[a];
            end
            #1;
            chk($sformatf("%s.done@%0d", tag, i), b_done, (i == WS_B + 1));
            chk($sformatf("%s.busy@%0d", tag, i), b_busy, (i < WS_B + 2));
            chk($sformatf("%s.mdat@%0d", tag, i), b_mdatain, exp_mdat_b);
        end
    endtask

    initial begin
        a_clear = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_mdr = '0;
        a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
        b_clear = 1'b1; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_mdr = '0;
        b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
        tick(); tick();
        chk("rst.a_mdat", a_mdatain, 0);
        chk("rst.a_done", a_done, 0);
        chk("rst.a_busy", a_busy, 0);
        chk("rst.a_err",  a_err, 0);
        chk("rst.b_mdat", b_mdatain, 0);
        chk("rst.b_busy", b_busy, 0);
        a_clear = 1'b0; b_clear = 1'b0;
        tick();

        for (int i = 0; i < 512; i++) preload_a(AW'(i), $urandom);
        preload_a(9'h095, 32'h0000_1234);

        // Plan 1: preload and read.
        req_a("p1_read95", 1'b0, 9'h095, '0, 1, 1'b0, 0, '0, '0);
        chk("p1.mdat", a_mdatain, 32'h0000_1234);

        // Plan 2: write then read back.
        req_a("p2_wr38", 1'b1, 9'h038, 32'hDEAD_BEEF, 1, 1'b0, 0, '0, '0);
        req_a("p2_rd38", 1'b0, 9'h038, '0, 2, 1'b0, 0, '0, '0);
        chk("p2.mdat", a_mdatain, 32'hDEAD_BEEF);

        // Plan 3: read strobe held for 10 cycles.
        req_a("p3_held", 1'b0, 9'h0A7, '0, 10, 1'b0, 0, '0, '0);

        // Plan 4: both strobes at once.
        a_rd = 1'b1; a_wr = 1'b1; a_addr = 9'h044; a_mdr = ~mem_a[9'h044];
        tick();
        chk("p4.err", a_err, 1);
        chk("p4.busy", a_busy, 1);
        chk("p4.done0", a_done, 0);
        tick();
        chk("p4.done1", a_done, 0);
        chk("p4.busy1", a_busy, 1);
        a_rd = 1'b0; a_wr = 1'b0;
        tick();
        chk("p4.busy_exit", a_busy, 0);
        chk("p4.done2", a_done, 0);
        req_a("p4_rd44", 1'b0, 9'h044, '0, 1, 1'b0, 0, '0, '0);

        // Plan 6: preload/write collision, then preload/read collision.
        req_a("p6_wr20", 1'b1, 9'h020, 32'hBBBB_BBBB, 1, 1'b1, WS_A + 1, 9'h020, 32'hAAAA_AAAA);
        req_a("p6_rd20", 1'b0, 9'h020, '0, 1, 1'b0, 0, '0, '0);
        chk("p6.mdat", a_mdatain, 32'hAAAA_AAAA);
        req_a("p6_rd21", 1'b0, 9'h021, '0, 1, 1'b1, WS_A + 1, 9'h021, 32'h1357_9BDF);
        req_a("p6_rd21b", 1'b0, 9'h021, '0, 1, 1'b0, 0, '0, '0);
        chk("p6.mdat21", a_mdatain, 32'h1357_9BDF);

        // Randomized transactions with occasional preloads and idle gaps.
        for (int t = 0; t < 40; t++) begin
            bit            w, pl;
            logic [AW-1:0] ad, pa;
            int            gap;
            w   = $urandom_range(0, 1);
            ad  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 511));
            pa  = AW'($urandom_range(0, 15));
            pl  = ($urandom_range(0, 3) == 0);
            req_a($sformatf("rnd%0d", t), w, ad, $urandom, $urandom_range(1, 4),
                  pl, $urandom_range(0, WS_A + 2), pa, $urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap.done", a_done, 0);
                chk("gap.busy", a_busy, 0);
            end
        end
        chk("p4.err_sticky", a_err, 1);

        // Plan 5: reset during WAIT on the WAIT_STATES=3 instance.
        preload_b(9'h010, 32'h0BAD_F00D);
        preload_b(9'h011, 32'h7654_3210);
        req_b("b_rd11", 1'b0, 9'h011, '0);
        chk("b.mdat11", b_mdatain, 32'h7654_3210);
        b_rd = 1'b0; b_wr = 1'b1; b_addr = 9'h010; b_mdr = 32'h5555_5555;
        tick();
        b_wr = 1'b0;
        tick();
        chk("p5.busy_wait", b_busy, 1);
        #2 b_clear = 1'b1;
        #1;
        exp_mdat_b = '0;
        chk("p5.clr_mdat", b_mdatain, 0);
        chk("p5.clr_done", b_done, 0);
        chk("p5.clr_busy", b_busy, 0);
        chk("p5.clr_err",  b_err, 0);
        tick();
        b_clear = 1'b0;
        tick(); tick(); tick();
        chk("p5.idle_done", b_done, 0);
        req_b("p5_rd10", 1'b0, 9'h010, '0);
        chk("p5.mdat10", b_mdatain, 32'h0BAD_F00D);

        // mem_err clears only with reset.
        a_clear = 1'b1;
        tick();
        chk("end.err_clr", a_err, 0);
        chk("end.mdat_clr", a_mdatain, 0);
        a_clear = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
